// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neuron_pkg
// Brief    : Shared word/vector types and the backprop collector state type
//            used across the neuron training datapath.
// Revision : 1.0 - initial release
// ============================================================================
package neuron_pkg;

   localparam int WORD_W    = 32;
   localparam int DENDRITES = 32;

   typedef logic signed [WORD_W-1:0] word_t;
   typedef word_t [DENDRITES-1:0]    word_vec_t;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } bp_state_e;

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/backprop_add.sv
`default_nettype none
// ============================================================================
// Module   : backprop_add
// Brief    : Single-lane WIDTH-bit signed adder. Wraps modulo 2^WIDTH by
//            default; with BACKPROP_SAT_EN defined it clamps to the signed
//            range and reports the clip on a dedicated output.
// Revision : 1.0 - initial release
// ============================================================================
module backprop_add #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] sum
`ifdef BACKPROP_SAT_EN
   ,
   output logic                    clip
`endif
);

`ifdef BACKPROP_SAT_EN
   localparam logic signed [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0] w_ext;

   // One guard bit detects overflow: the top two bits disagree only when the
   // true sum left the signed range, and the guard bit gives its direction.
   always_comb begin
      w_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      clip  = w_ext[WIDTH] ^ w_ext[WIDTH-1];
      if (clip) begin
         sum = w_ext[WIDTH] ? C_MIN : C_MAX;
      end else begin
         sum = w_ext[WIDTH-1:0];
      end
   end
`else
   assign sum = a + b;
`endif

endmodule : backprop_add
`default_nettype wire

// File: rtl/backprop_collector.sv
`default_nettype none
// ============================================================================
// Module   : backprop_collector
// Brief    : Sums NUM_SOURCES per-dendrite backprop vectors element-wise and
//            presents the result to the previous layer over a valid/ready
//            handshake. Optional macro BACKPROP_SAT_EN selects saturating
//            lane adds and enables the sticky out_saturated flag.
// Revision : 1.0 - initial release
// ============================================================================
module backprop_collector
   import neuron_pkg::*;
#(
   parameter int WIDTH       = WORD_W,
   parameter int INPUTS      = DENDRITES,
   parameter int NUM_SOURCES = 4
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [INPUTS-1:0][WIDTH-1:0]   in_change,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [INPUTS-1:0][WIDTH-1:0]   out_backprop,
   output logic                           out_saturated
);

   localparam int              C_CNT_W = $clog2(NUM_SOURCES + 1);
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(NUM_SOURCES - 1);

   bp_state_e                      state_q, state_d;
   logic [C_CNT_W-1:0]             count_q, count_d;
   logic [INPUTS-1:0][WIDTH-1:0]   acc_q, acc_d;
   logic [INPUTS-1:0][WIDTH-1:0]   w_sum;
   logic                           w_accept;

`ifdef BACKPROP_SAT_EN
   logic [INPUTS-1:0]              w_clip;
   logic                           sat_q, sat_d;
`endif

   // One adder per dendrite lane; lanes never interact.
   generate
      for (genvar g = 0; g < INPUTS; g++) begin : g_lane
         backprop_add #(
            .WIDTH (WIDTH)
         ) u_add (
            .a    (acc_q[g]),
            .b    (in_change[g]),
            .sum  (w_sum[g])
`ifdef BACKPROP_SAT_EN
            ,
            .clip (w_clip[g])
`endif
         );
      end
   endgenerate

   // Handshake outputs come from state only; next state, count and lanes.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      w_accept  = 1'b0;
      in_ready  = (state_q == ACCUM);
      out_valid = (state_q == HOLD);
      case (state_q)
         ACCUM: begin
            if (in_valid) begin
               w_accept = 1'b1;
               acc_d    = w_sum;
               if (count_q == C_LAST) begin
                  state_d = HOLD;
                  count_d = '0;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               acc_d   = '0;
               state_d = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
            count_d = '0;
            acc_d   = '0;
         end
      endcase
   end

   // State, beat counter and lane accumulators.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ACCUM;
         count_q <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
      end
   end

   assign out_backprop = acc_q;

`ifdef BACKPROP_SAT_EN
   // Sticky clip flag: set by any clipping lane on an accepted beat, cleared
   // when the sum is handed off.
   always_comb begin
      sat_d = sat_q;
      if (w_accept) begin
         sat_d = sat_q | (|w_clip);
      end else if ((state_q == HOLD) && out_ready) begin
         sat_d = 1'b0;
      end
   end

   // Clip flag register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= sat_d;
      end
   end

   assign out_saturated = sat_q;
`else
   assign out_saturated = 1'b0;
`endif

endmodule : backprop_collector
`default_nettype wire

// File: tb/tb_backprop_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_backprop_collector
// Brief    : Self-checking bench for backprop_collector (NUM_SOURCES=4 and
//            NUM_SOURCES=1 instances). Honours BACKPROP_SAT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_backprop_collector;

   localparam int W  = 32;
   localparam int N  = 32;
   localparam int VB = W * N;
`ifdef BACKPROP_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic                  a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sat;
   logic [N-1:0][W-1:0]   a_in_change, a_out;
   logic                  b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sat;
   logic [N-1:0][W-1:0]   b_in_change, b_out;

   backprop_collector #(.WIDTH(W), .INPUTS(N), .NUM_SOURCES(4)) u_dut4 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_change(a_in_change),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_backprop(a_out), .out_saturated(a_sat));

   backprop_collector #(.WIDTH(W), .INPUTS(N), .NUM_SOURCES(1)) u_dut1 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_change(b_in_change),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_backprop(b_out), .out_saturated(b_sat));

   int checks = 0;
   int errors = 0;

   // Beats accepted into the current sum of the 4-source instance.
   logic [VB-1:0] beats[$];

   task automatic check_vec(input string tag, input logic [VB-1:0] obs, input logic [VB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [VB-1:0] fill(input logic [W-1:0] v);
      logic [VB-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = v;
      return r;
   endfunction

   function automatic logic [VB-1:0] rand_vec();
      logic [VB-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = $urandom;
      return r;
   endfunction

   // Reference: plain integer sum per lane, then wrap or clamp after each add.
   function automatic logic [VB-1:0] model_sum(output logic clipped);
      logic [VB-1:0] r;
      longint        s, v, lim_hi, lim_lo;
      int            t;
      lim_hi  = 64'sd2147483647;
      lim_lo  = -64'sd2147483648;
      clipped = 1'b0;
      for (int k = 0; k < N; k++) begin
         s = 0;
         foreach (beats[i]) begin
            t = beats[i][k*W +: W];
            v = t;
            s = s + v;
            if (SAT) begin
               if (s > lim_hi) begin s = lim_hi; clipped = 1'b1; end
               if (s < lim_lo) begin s = lim_lo; clipped = 1'b1; end
            end else begin
               t = s[31:0];
               s = t;
            end
         end
         r[k*W +: W] = s[31:0];
      end
      return r;
   endfunction

   // Offer one beat to the 4-source instance and wait (bounded) for acceptance.
   task automatic send4(input logic [VB-1:0] v);
      int n = 0;
      @(negedge clock);
      a_in_valid  = 1'b1;
      a_in_change = v;
      while (!a_in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      check_bit("accept_ready", a_in_ready, 1'b1);
      if (a_in_ready) begin
         check_bit("ov_low_in_accum", a_out_valid, 1'b0);
         @(posedge clock);
         beats.push_back(v);
      end
      #1 a_in_valid = 1'b0;
   endtask

   // Expect the sum in the cycle after the last beat, hold it, then consume.
   task automatic collect4(input string tag, input int hold, input bit push_during_hold);
      logic [VB-1:0] exp;
      logic          exp_sat;
      exp = model_sum(exp_sat);
      @(negedge clock);
      check_bit({tag, "_out_valid"}, a_out_valid, 1'b1);
      check_vec({tag, "_sum"}, a_out, exp);
      check_bit({tag, "_sat"}, a_sat, exp_sat);
      for (int i = 0; i < hold; i++) begin
         if (push_during_hold) begin
            a_in_valid  = 1'b1;
            a_in_change = rand_vec();
         end
         @(negedge clock);
         check_bit({tag, "_hold_in_ready"}, a_in_ready, 1'b0);
         check_bit({tag, "_hold_out_valid"}, a_out_valid, 1'b1);
         check_vec({tag, "_hold_stable"}, a_out, exp);
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      @(posedge clock);
      #1 a_out_ready = 1'b0;
      beats.delete();
      @(negedge clock);
      check_bit({tag, "_post_in_ready"}, a_in_ready, 1'b1);
      check_bit({tag, "_post_out_valid"}, a_out_valid, 1'b0);
      check_vec({tag, "_post_clear"}, a_out, '0);
      check_bit({tag, "_post_sat"}, a_sat, 1'b0);
   endtask

   initial begin
      logic [VB-1:0] v;
      logic [VB-1:0] pend;
      int            outs;

      a_in_valid = 0; a_out_ready = 0; a_in_change = '0;
      b_in_valid = 0; b_out_ready = 0; b_in_change = '0;
      pend = '0;

      // Reset state.
      repeat (2) @(negedge clock);
      check_bit("rst_out_valid", a_out_valid, 1'b0);
      check_vec("rst_out", a_out, '0);
      check_bit("rst_sat", a_sat, 1'b0);
      reset_n = 1'b1;
      @(negedge clock);
      check_bit("rst_in_ready", a_in_ready, 1'b1);
      check_bit("rst_in_ready_n1", b_in_ready, 1'b1);

      // Basic sum 1+2+3+4.
      for (int i = 1; i <= 4; i++) send4(fill(W'(i)));
      collect4("basic", 0, 1'b0);

      // Lane independence: lane k = k + (-2k) = -k.
      for (int k = 0; k < N; k++) v[k*W +: W] = W'(k);
      send4(v);
      for (int k = 0; k < N; k++) v[k*W +: W] = W'(-2 * k);
      send4(v);
      send4('0);
      send4('0);
      @(negedge clock);
      check_vec("lane_lane31", {{(VB-W){1'b0}}, a_out[31]}, {{(VB-W){1'b0}}, 32'hFFFF_FFE1});
      check_vec("lane_lane1", {{(VB-W){1'b0}}, a_out[1]}, {{(VB-W){1'b0}}, 32'hFFFF_FFFF});
      collect4("lane", 0, 1'b0);

      // Backpressure with in_valid held high during HOLD.
      for (int i = 0; i < 4; i++) send4(rand_vec());
      collect4("bp", 5, 1'b1);
      for (int i = 0; i < 4; i++) send4(fill(32'd5));
      collect4("bp_restart", 0, 1'b0);

      // Reset mid-accumulation discards the partial sum.
      send4(fill(32'd7));
      send4(fill(32'd7));
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      beats.delete();
      check_bit("midrst_out_valid", a_out_valid, 1'b0);
      check_vec("midrst_out", a_out, '0);
      @(negedge clock);
      reset_n = 1'b1;
      #1 check_bit("midrst_in_ready", a_in_ready, 1'b1);
      for (int i = 0; i < 4; i++) send4(fill(32'd1));
      check_vec("midrst_four", a_out, fill(32'd4));
      collect4("midrst", 0, 1'b0);

      // Overflow on lane 0.
      v = '0; v[W-1:0] = 32'h7FFF_FFF0;
      send4(v);
      v = '0; v[W-1:0] = 32'h0000_0020;
      send4(v);
      send4('0);
      send4('0);
      @(negedge clock);
      if (SAT) begin
         check_vec("ovf_lane0", {{(VB-W){1'b0}}, a_out[0]}, {{(VB-W){1'b0}}, 32'h7FFF_FFFF});
      end else begin
         check_vec("ovf_lane0", {{(VB-W){1'b0}}, a_out[0]}, {{(VB-W){1'b0}}, 32'h8000_0010});
      end
      check_bit("ovf_sat", a_sat, SAT);
      collect4("ovf", 0, 1'b0);

      // Randomised sums with random gaps and hold lengths.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            send4(rand_vec());
         end
         collect4("rand", $urandom_range(0, 3), 1'b1);
      end

      // NUM_SOURCES=1: continuous valid/ready, one output every 2 cycles.
      outs = 0;
      @(negedge clock);
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (b_out_valid) begin
            outs++;
            check_vec("n1_out", b_out, pend);
         end
         check_bit("n1_ready_pattern", b_in_ready, (i % 2) == 0);
         b_in_change = fill(W'(i + 1));
         if (b_in_ready) pend = fill(W'(i + 1));
         @(negedge clock);
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b0;
      checks++;
      assert (outs == 6) else begin
         errors++;
         $error("FAIL n1_out_count: observed %0d expected %0d", outs, 6);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_backprop_collector
`default_nettype wire
